cpu6_trap_seq: RTL and testbench

- Parametrised trap sequencer for the cpu6 pipeline, successor to the fixed two-source (timer/external) trap path.
- Accepts NIRQ level interrupt lines plus the illegal-instruction exception and mret.
- Arbitrates between them, runs the drain-pipeline request/ack handshake with a bounded timeout, then issues a one-cycle flush with redirect PC and the CSR write strobes (mepc, mcause, MIE).
- Sits between the controller/datapath and the PC mux; its flush has priority over branch redirect.

---
 rtl/cpu6_trap_seq_if.sv | 41 ++++
 rtl/cpu6_trap_seq.sv | 188 ++++++++++++++++++
 tb/tb_cpu6_trap_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu6_trap_seq_if.sv
// Trap sequencer bus: trap requests and CSR values in, drain handshake, flush and CSR strobes out.
interface cpu6_trap_seq_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NIRQ = 4
);
    logic [NIRQ-1:0] irq;
    logic [NIRQ-1:0] irq_en;
    logic            csr_mstatus_mie_r;
    logic            illinstr;
    logic            mret;
    logic [XLEN-1:0] excp_pc;
    logic [XLEN-1:0] csr_mtvec;
    logic [XLEN-1:0] csr_mepc;
    logic            drain_ack;
    logic            drain_req;
    logic            stall;
    logic            flush_ena;
    logic [XLEN-1:0] flush_pc;
    logic            mepc_wr_ena;
    logic [XLEN-1:0] mepc_wr;
    logic [XLEN-1:0] mcause_wr;
    logic            mie_clr;
    logic            mie_restore;
    logic            drain_timeout;

    // Controller/datapath side
    modport master (
        output irq, irq_en, csr_mstatus_mie_r, illinstr, mret,
               excp_pc, csr_mtvec, csr_mepc, drain_ack,
        input  drain_req, stall, flush_ena, flush_pc, mepc_wr_ena,
               mepc_wr, mcause_wr, mie_clr, mie_restore, drain_timeout
    );

    // Sequencer side
    modport slave (
        input  irq, irq_en, csr_mstatus_mie_r, illinstr, mret,
               excp_pc, csr_mtvec, csr_mepc, drain_ack,
        output drain_req, stall, flush_ena, flush_pc, mepc_wr_ena,
               mepc_wr, mcause_wr, mie_clr, mie_restore, drain_timeout
    );
endinterface

// File: rtl/cpu6_trap_seq.sv
// cpu6 trap sequencer: arbitrates illegal-instruction / NIRQ interrupts / mret, drains the pipeline, issues flush.
// Optional vectored interrupt targets enabled by defining CPU6_TRAP_VECTORED_EN.
module cpu6_trap_seq #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned NIRQ          = 4,
    parameter int unsigned IRQ_CODE_BASE = 16,
    parameter int unsigned DRAIN_MAX     = 15
) (
    input  logic          clk,
    input  logic          reset,
    cpu6_trap_seq_if.slave bus
);

    localparam int unsigned CW = $clog2(DRAIN_MAX + 1);
    localparam logic [XLEN-1:0] IRQ_FLAG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] CAUSE_ILL = XLEN'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            ret_q, ret_d;
    logic            timeout_q, timeout_d;

    logic            drain_req_q, drain_req_d;
    logic            stall_q, stall_d;
    logic            flush_ena_q, flush_ena_d;
    logic [XLEN-1:0] flush_pc_q, flush_pc_d;
    logic            mepc_wr_ena_q, mepc_wr_ena_d;
    logic [XLEN-1:0] mepc_wr_q, mepc_wr_d;
    logic [XLEN-1:0] mcause_wr_q, mcause_wr_d;
    logic            mie_clr_q, mie_clr_d;
    logic            mie_restore_q, mie_restore_d;

    logic [NIRQ-1:0] pend;
    logic [XLEN-1:0] irq_code;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] trap_pc;

    assign pend = bus.irq & bus.irq_en & {NIRQ{bus.csr_mstatus_mie_r}};
    assign base = bus.csr_mtvec & ~XLEN'(3);

    // Lowest pending index wins
    always_comb begin
        irq_code = '0;
        for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
            if (pend[i]) irq_code = XLEN'(IRQ_CODE_BASE) + XLEN'(i);
        end
    end

    // Trap redirect target from the latched cause
    always_comb begin
        trap_pc = base;
`ifdef CPU6_TRAP_VECTORED_EN
        if (bus.csr_mtvec[1:0] == 2'b01 && cause_q[XLEN-1])
            trap_pc = base + ((cause_q & ~IRQ_FLAG) << 2);
`else
        trap_pc = base;
`endif
    end

    // Next state, latches and next registered outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cause_d       = cause_q;
        epc_d         = epc_q;
        ret_d         = ret_q;
        timeout_d     = timeout_q;
        drain_req_d   = 1'b0;
        stall_d       = 1'b0;
        flush_ena_d   = 1'b0;
        flush_pc_d    = '0;
        mepc_wr_ena_d = 1'b0;
        mepc_wr_d     = '0;
        mcause_wr_d   = '0;
        mie_clr_d     = 1'b0;
        mie_restore_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.illinstr) begin
                    cause_d = CAUSE_ILL;
                    epc_d   = bus.excp_pc;
                    ret_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else if (|pend) begin
                    cause_d = IRQ_FLAG | irq_code;
                    epc_d   = bus.excp_pc;
                    ret_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else if (bus.mret) begin
                    cause_d = '0;
                    epc_d   = '0;
                    ret_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.drain_ack) begin
                    state_d = FLUSH;
                end else if (cnt_q == CW'(DRAIN_MAX - 1)) begin
                    state_d   = FLUSH;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FLUSH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        drain_req_d = (state_d == DRAIN);
        stall_d     = (state_d != IDLE);

        // FLUSH is only entered from DRAIN, so the latched request is stable here
        if (state_d == FLUSH) begin
            flush_ena_d = 1'b1;
            if (ret_q) begin
                flush_pc_d    = bus.csr_mepc;
                mie_restore_d = 1'b1;
            end else begin
                flush_pc_d    = trap_pc;
                mepc_wr_ena_d = 1'b1;
                mepc_wr_d     = epc_q;
                mcause_wr_d   = cause_q;
                mie_clr_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cause_q       <= '0;
            epc_q         <= '0;
            ret_q         <= 1'b0;
            timeout_q     <= 1'b0;
            drain_req_q   <= 1'b0;
            stall_q       <= 1'b0;
            flush_ena_q   <= 1'b0;
            flush_pc_q    <= '0;
            mepc_wr_ena_q <= 1'b0;
            mepc_wr_q     <= '0;
            mcause_wr_q   <= '0;
            mie_clr_q     <= 1'b0;
            mie_restore_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cause_q       <= cause_d;
            epc_q         <= epc_d;
            ret_q         <= ret_d;
            timeout_q     <= timeout_d;
            drain_req_q   <= drain_req_d;
            stall_q       <= stall_d;
            flush_ena_q   <= flush_ena_d;
            flush_pc_q    <= flush_pc_d;
            mepc_wr_ena_q <= mepc_wr_ena_d;
            mepc_wr_q     <= mepc_wr_d;
            mcause_wr_q   <= mcause_wr_d;
            mie_clr_q     <= mie_clr_d;
            mie_restore_q <= mie_restore_d;
        end
    end

    assign bus.drain_req     = drain_req_q;
    assign bus.stall         = stall_q;
    assign bus.flush_ena     = flush_ena_q;
    assign bus.flush_pc      = flush_pc_q;
    assign bus.mepc_wr_ena   = mepc_wr_ena_q;
    assign bus.mepc_wr       = mepc_wr_q;
    assign bus.mcause_wr     = mcause_wr_q;
    assign bus.mie_clr       = mie_clr_q;
    assign bus.mie_restore   = mie_restore_q;
    assign bus.drain_timeout = timeout_q;

endmodule

// File: tb/tb_cpu6_trap_seq.sv
// Directed bench for cpu6_trap_seq: reset abort, each trap source, arbitration, drain timeout, back-to-back.
module tb_cpu6_trap_seq;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passed = 0;

    cpu6_trap_seq_if #(.XLEN(32), .NIRQ(4)) bus ();

    cpu6_trap_seq #(
        .XLEN(32), .NIRQ(4), .IRQ_CODE_BASE(16), .DRAIN_MAX(15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic seen;
        reset = 1'b0;
        bus.irq = '0; bus.irq_en = '0; bus.csr_mstatus_mie_r = 1'b0;
        bus.illinstr = 1'b0; bus.mret = 1'b0; bus.drain_ack = 1'b0;
        bus.excp_pc = '0; bus.csr_mtvec = 32'h8000_0000; bus.csr_mepc = '0;
        repeat (2) tick();
        checks++;
        if ({bus.drain_req, bus.stall, bus.flush_ena, bus.mepc_wr_ena, bus.mie_clr,
             bus.mie_restore, bus.drain_timeout} !== 7'b0 || bus.flush_pc !== 32'h0 ||
            bus.mepc_wr !== 32'h0 || bus.mcause_wr !== 32'h0)
            $display("FAIL reset_outputs drain_req=%0b flush_ena=%0b flush_pc=%h mcause=%h", bus.drain_req, bus.flush_ena, bus.flush_pc, bus.mcause_wr);
        else passed++;
        reset = 1'b1;
        tick();
        bus.irq = 4'b0010; bus.irq_en = 4'hF; bus.csr_mstatus_mie_r = 1'b1;
        tick();
        checks++;
        if (bus.drain_req !== 1'b1 || bus.stall !== 1'b1)
            $display("FAIL reset_pre_drain drain_req=%0b stall=%0b expected 1/1", bus.drain_req, bus.stall);
        else passed++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.drain_req, bus.stall, bus.flush_ena, bus.mepc_wr_ena, bus.mie_clr,
             bus.mie_restore, bus.drain_timeout} !== 7'b0)
            $display("FAIL reset_mid_drain strobes=%b expected 0", {bus.drain_req, bus.stall, bus.flush_ena, bus.mepc_wr_ena, bus.mie_clr, bus.mie_restore, bus.drain_timeout});
        else passed++;
        bus.irq = '0;
        bus.drain_ack = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.flush_ena || bus.drain_req) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0)
            $display("FAIL reset_post_idle activity_seen=%0b expected 0", seen);
        else passed++;
        bus.drain_ack = 1'b0;
    endtask

    task automatic test_illinstr();
        bus.excp_pc = 32'h100; bus.csr_mtvec = 32'h8000_0000; bus.drain_ack = 1'b0;
        bus.illinstr = 1'b1;
        tick();                                   // N+1
        bus.illinstr = 1'b0;
        checks++;
        if (bus.drain_req !== 1'b1 || bus.stall !== 1'b1 || bus.flush_ena !== 1'b0)
            $display("FAIL ill_drain drain_req=%0b stall=%0b flush=%0b expected 1/1/0", bus.drain_req, bus.stall, bus.flush_ena);
        else passed++;
        tick();                                   // N+2
        tick();                                   // N+3
        bus.drain_ack = 1'b1;
        checks++;
        if (bus.flush_ena !== 1'b0 || bus.drain_req !== 1'b1)
            $display("FAIL ill_wait flush=%0b drain_req=%0b expected 0/1", bus.flush_ena, bus.drain_req);
        else passed++;
        tick();                                   // N+4
        checks++;
        if (bus.flush_ena !== 1'b1 || bus.flush_pc !== 32'h8000_0000 || bus.stall !== 1'b1 || bus.drain_req !== 1'b0)
            $display("FAIL ill_flush flush=%0b pc=%h stall=%0b expected 1/80000000/1", bus.flush_ena, bus.flush_pc, bus.stall);
        else passed++;
        checks++;
        if (bus.mepc_wr_ena !== 1'b1 || bus.mepc_wr !== 32'h100 || bus.mcause_wr !== 32'h2 ||
            bus.mie_clr !== 1'b1 || bus.mie_restore !== 1'b0)
            $display("FAIL ill_csr we=%0b mepc=%h mcause=%h clr=%0b rst=%0b expected 1/100/2/1/0", bus.mepc_wr_ena, bus.mepc_wr, bus.mcause_wr, bus.mie_clr, bus.mie_restore);
        else passed++;
        tick();                                   // N+5
        checks++;
        if (bus.flush_ena !== 1'b0 || bus.stall !== 1'b0 || bus.mepc_wr_ena !== 1'b0 || bus.mie_clr !== 1'b0)
            $display("FAIL ill_after flush=%0b stall=%0b we=%0b clr=%0b expected 0", bus.flush_ena, bus.stall, bus.mepc_wr_ena, bus.mie_clr);
        else passed++;
    endtask

    task automatic test_irq();
        logic [31:0] exp_pc;
`ifdef CPU6_TRAP_VECTORED_EN
        exp_pc = 32'h1044;
`else
        exp_pc = 32'h1000;
`endif
        bus.drain_ack = 1'b1; bus.csr_mtvec = 32'h1001; bus.excp_pc = 32'h200;
        bus.irq = 4'b0110; bus.irq_en = 4'hF; bus.csr_mstatus_mie_r = 1'b1;
        tick();
        bus.irq = '0;                             // drop during DRAIN must not cancel
        checks++;
        if (bus.drain_req !== 1'b1)
            $display("FAIL irq_drain drain_req=%0b expected 1", bus.drain_req);
        else passed++;
        tick();
        checks++;
        if (bus.flush_ena !== 1'b1 || bus.mcause_wr !== 32'h8000_0011 || bus.mepc_wr !== 32'h200 || bus.mie_clr !== 1'b1)
            $display("FAIL irq_flush flush=%0b mcause=%h mepc=%h clr=%0b expected 1/80000011/200/1", bus.flush_ena, bus.mcause_wr, bus.mepc_wr, bus.mie_clr);
        else passed++;
        checks++;
        if (bus.flush_pc !== exp_pc)
            $display("FAIL irq_target flush_pc=%h expected %h", bus.flush_pc, exp_pc);
        else passed++;
        tick();
        bus.csr_mtvec = 32'h8000_0000;
    endtask

    task automatic test_mret();
        bus.csr_mstatus_mie_r = 1'b0; bus.irq = 4'hF; bus.irq_en = 4'hF;
        bus.mret = 1'b1; bus.csr_mepc = 32'h300; bus.drain_ack = 1'b1;
        tick();
        bus.mret = 1'b0; bus.irq = '0;
        tick();
        checks++;
        if (bus.flush_ena !== 1'b1 || bus.flush_pc !== 32'h300 || bus.mie_restore !== 1'b1)
            $display("FAIL mret_flush flush=%0b pc=%h restore=%0b expected 1/300/1", bus.flush_ena, bus.flush_pc, bus.mie_restore);
        else passed++;
        checks++;
        if (bus.mepc_wr_ena !== 1'b0 || bus.mcause_wr !== 32'h0 || bus.mie_clr !== 1'b0)
            $display("FAIL mret_csr we=%0b mcause=%h clr=%0b expected 0/0/0", bus.mepc_wr_ena, bus.mcause_wr, bus.mie_clr);
        else passed++;
        tick();
    endtask

    task automatic test_irq_vs_mret();
        bus.csr_mstatus_mie_r = 1'b1; bus.irq = 4'b0001; bus.irq_en = 4'hF;
        bus.mret = 1'b1; bus.excp_pc = 32'h400; bus.drain_ack = 1'b1;
        tick();
        bus.mret = 1'b0; bus.irq = '0;
        tick();
        checks++;
        if (bus.flush_ena !== 1'b1 || bus.mcause_wr !== 32'h8000_0010 || bus.mie_restore !== 1'b0 ||
            bus.mie_clr !== 1'b1 || bus.mepc_wr !== 32'h400 || bus.flush_pc !== 32'h8000_0000)
            $display("FAIL irq_mret mcause=%h restore=%0b clr=%0b mepc=%h pc=%h expected 80000010/0/1/400/80000000", bus.mcause_wr, bus.mie_restore, bus.mie_clr, bus.mepc_wr, bus.flush_pc);
        else passed++;
        tick();
    endtask

    task automatic test_timeout();
        int k;
        bus.drain_ack = 1'b0; bus.excp_pc = 32'h180;
        checks++;
        if (bus.drain_timeout !== 1'b0)
            $display("FAIL to_initial drain_timeout=%0b expected 0", bus.drain_timeout);
        else passed++;
        bus.illinstr = 1'b1;
        tick();
        bus.illinstr = 1'b0;
        k = 0;
        while (bus.flush_ena !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        checks++;
        if (k !== 15)
            $display("FAIL to_latency cycles=%0d expected 15", k);
        else passed++;
        checks++;
        if (bus.drain_timeout !== 1'b1 || bus.mcause_wr !== 32'h2 || bus.mepc_wr !== 32'h180)
            $display("FAIL to_flush timeout=%0b mcause=%h mepc=%h expected 1/2/180", bus.drain_timeout, bus.mcause_wr, bus.mepc_wr);
        else passed++;
        tick();
        checks++;
        if (bus.drain_timeout !== 1'b1 || bus.flush_ena !== 1'b0)
            $display("FAIL to_sticky timeout=%0b flush=%0b expected 1/0", bus.drain_timeout, bus.flush_ena);
        else passed++;
    endtask

    task automatic test_back_to_back();
        bus.drain_ack = 1'b1; bus.excp_pc = 32'h500;
        bus.illinstr = 1'b1;                      // held across the whole sequence
        tick();                                   // DRAIN
        tick();                                   // FLUSH
        checks++;
        if (bus.flush_ena !== 1'b1 || bus.mepc_wr !== 32'h500)
            $display("FAIL b2b_first flush=%0b mepc=%h expected 1/500", bus.flush_ena, bus.mepc_wr);
        else passed++;
        tick();                                   // IDLE, request sampled
        checks++;
        if (bus.flush_ena !== 1'b0 || bus.drain_req !== 1'b0 || bus.stall !== 1'b0)
            $display("FAIL b2b_idle flush=%0b drain_req=%0b stall=%0b expected 0/0/0", bus.flush_ena, bus.drain_req, bus.stall);
        else passed++;
        tick();                                   // DRAIN again
        checks++;
        if (bus.drain_req !== 1'b1)
            $display("FAIL b2b_redrain drain_req=%0b expected 1", bus.drain_req);
        else passed++;
        bus.illinstr = 1'b0;
        tick();                                   // second FLUSH
        checks++;
        if (bus.flush_ena !== 1'b1 || bus.drain_timeout !== 1'b1 || bus.mcause_wr !== 32'h2)
            $display("FAIL b2b_second flush=%0b timeout=%0b mcause=%h expected 1/1/2", bus.flush_ena, bus.drain_timeout, bus.mcause_wr);
        else passed++;
        repeat (2) tick();
        checks++;
        if (bus.flush_ena !== 1'b0 || bus.stall !== 1'b0 || bus.drain_timeout !== 1'b1)
            $display("FAIL b2b_end flush=%0b stall=%0b timeout=%0b expected 0/0/1", bus.flush_ena, bus.stall, bus.drain_timeout);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_illinstr();
        test_irq();
        test_mret();
        test_irq_vs_mret();
        test_timeout();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
